// File: rtl/spart_pkg.sv
// ============================================================================
// Module   : spart_pkg
// Purpose  : Shared types, default constants and helpers for the SPART receiver.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package spart_pkg;

    localparam int SPART_OVERSAMPLE = 16;
    localparam int SPART_DATA_BITS  = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } rx_state_t;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

`default_nettype wire

// File: rtl/spart_rx_if.sv
// ============================================================================
// Module   : spart_rx_if
// Purpose  : CPU-side receive buffer signals between spart_rx and the SPART top.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface spart_rx_if
    import spart_pkg::*;
#(
    parameter int DATA_BITS = SPART_DATA_BITS
);
    logic                 rd_strobe;
    logic [DATA_BITS-1:0] data;
    logic                 rda;
    logic                 frame_err;
    logic                 overrun;

    modport master (
        output rd_strobe,
        input  data,
        input  rda,
        input  frame_err,
        input  overrun
    );

    modport slave (
        input  rd_strobe,
        output data,
        output rda,
        output frame_err,
        output overrun
    );
endinterface

`default_nettype wire

// File: rtl/spart_sync2.sv
// ============================================================================
// Module   : spart_sync2
// Purpose  : Two-flop synchroniser with a parameterised reset value.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module spart_sync2 #(
    parameter logic RESET_VAL = 1'b0
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic d,
    output logic      q
);
    logic [1:0] r_sync;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync <= {2{RESET_VAL}};
        end else begin
            r_sync <= {r_sync[0], d};
        end
    end

    assign q = r_sync[1];
endmodule

`default_nettype wire

// File: rtl/spart_rx.sv
// ============================================================================
// Module   : spart_rx
// Purpose  : SPART receiver, 8N1 deserialiser on a 16x oversample tick.
//            Optional SPART_RX_MAJORITY_EN: 2-of-3 majority at every sample point.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module spart_rx
    import spart_pkg::*;
#(
    parameter int DATA_BITS  = SPART_DATA_BITS,
    parameter int OVERSAMPLE = SPART_OVERSAMPLE,
    parameter int MID        = OVERSAMPLE / 2
) (
    input  wire logic   clk,
    input  wire logic   rst,
    input  wire logic   r_enable,
    input  wire logic   rxd,
    spart_rx_if.slave   bus
);
    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS + 1);

    localparam logic [TW-1:0] c_tick_last = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] c_bits_last = BW'(DATA_BITS - 1);
`ifdef SPART_RX_MAJORITY_EN
    // Decision one tick later so the three-sample window straddles the midpoint.
    localparam logic [TW-1:0] c_start_last = TW'(MID);
`else
    localparam logic [TW-1:0] c_start_last = TW'(MID - 1);
`endif

    logic                 w_rxs;
    logic                 w_sample;
    rx_state_t            r_state, w_state_next;
    logic [TW-1:0]        r_tick, w_tick_next;
    logic [BW-1:0]        r_bit, w_bit_next;
    logic [DATA_BITS-1:0] r_shift, w_shift_next;
    logic [DATA_BITS-1:0] r_data;
    logic                 r_rda, r_ferr, r_ovr;
    logic                 w_commit, w_ferr_set;

    spart_sync2 #(.RESET_VAL(1'b1)) u_sync_rxd (
        .clk (clk),
        .rst (rst),
        .d   (rxd),
        .q   (w_rxs)
    );

`ifdef SPART_RX_MAJORITY_EN
    logic [1:0] r_hist;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hist <= 2'b11;
        end else if (r_enable) begin
            r_hist <= {r_hist[0], w_rxs};
        end
    end

    assign w_sample = majority3(r_hist[1], r_hist[0], w_rxs);
`else
    assign w_sample = w_rxs;
`endif

    always_comb begin
        w_state_next = r_state;
        w_tick_next  = r_tick;
        w_bit_next   = r_bit;
        w_shift_next = r_shift;
        w_commit     = 1'b0;
        w_ferr_set   = 1'b0;
        if (r_enable) begin
            case (r_state)
                IDLE: begin
                    if (!w_rxs) begin
                        w_state_next = START;
                        w_tick_next  = '0;
                    end
                end
                START: begin
                    if (r_tick == c_start_last) begin
                        if (w_sample) begin
                            w_state_next = IDLE;
                        end else begin
                            w_state_next = DATA;
                            w_tick_next  = '0;
                            w_bit_next   = '0;
                        end
                    end else begin
                        w_tick_next = r_tick + TW'(1);
                    end
                end
                DATA: begin
                    if (r_tick == c_tick_last) begin
                        w_tick_next  = '0;
                        w_shift_next = {w_sample, r_shift[DATA_BITS-1:1]};
                        w_bit_next   = r_bit + BW'(1);
                        if (r_bit == c_bits_last) begin
                            w_state_next = STOP;
                        end
                    end else begin
                        w_tick_next = r_tick + TW'(1);
                    end
                end
                STOP: begin
                    if (r_tick == c_tick_last) begin
                        w_tick_next = '0;
                        if (w_sample) begin
                            w_commit     = 1'b1;
                            w_state_next = IDLE;
                        end else begin
                            w_ferr_set   = 1'b1;
                            w_state_next = BREAK;
                        end
                    end else begin
                        w_tick_next = r_tick + TW'(1);
                    end
                end
                BREAK: begin
                    // Hold here until the line recovers so a stuck-low line cannot re-trigger.
                    if (w_rxs) begin
                        w_state_next = IDLE;
                    end
                end
                default: w_state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_tick  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_data  <= '0;
            r_rda   <= 1'b0;
            r_ferr  <= 1'b0;
            r_ovr   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_tick  <= w_tick_next;
            r_bit   <= w_bit_next;
            r_shift <= w_shift_next;
            if (w_commit) begin
                r_data <= r_shift;
            end
            // A read on the commit clock consumes the old byte, so no overrun.
            r_rda  <= w_commit | (r_rda & ~bus.rd_strobe);
            r_ferr <= w_ferr_set | (r_ferr & ~bus.rd_strobe);
            r_ovr  <= (w_commit & r_rda & ~bus.rd_strobe) | (r_ovr & ~bus.rd_strobe);
        end
    end

    assign bus.data      = r_data;
    assign bus.rda       = r_rda;
    assign bus.frame_err = r_ferr;
    assign bus.overrun   = r_ovr;
endmodule

`default_nettype wire

// File: tb/tb_spart_rx.sv
// ============================================================================
// Module   : tb_spart_rx
// Purpose  : Self-checking bench for spart_rx: frame table plus corner sequences.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_spart_rx;
    import spart_pkg::*;

`ifdef SPART_RX_MAJORITY_EN
    localparam int C_COMMIT     = 154;
    localparam int C_GLITCH_OFF = 8;
`else
    localparam int C_COMMIT     = 153;
    localparam int C_GLITCH_OFF = 1;
`endif

    logic clk      = 1'b0;
    logic rst      = 1'b0;
    logic r_enable = 1'b0;
    logic rxd      = 1'b1;

    spart_rx_if #(.DATA_BITS(8)) bus ();

    spart_rx dut (
        .clk      (clk),
        .rst      (rst),
        .r_enable (r_enable),
        .rxd      (rxd),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit         pre_read;
        logic [7:0] b;
        logic       stop;
        int         hold_low;
        logic [7:0] e_data;
        logic       e_rda;
        logic       e_fe;
        logic       e_ov;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [7:0] d, input logic a,
                             input logic fe, input logic ov);
        check({tag, ".data"},      bus.data,            d);
        check({tag, ".rda"},       8'(bus.rda),         8'(a));
        check({tag, ".frame_err"}, 8'(bus.frame_err),   8'(fe));
        check({tag, ".overrun"},   8'(bus.overrun),     8'(ov));
    endtask

    // One oversample tick = 4 clocks; r_enable (and optionally rd_strobe) high on the last.
    task automatic tick(input logic strobe);
        repeat (3) @(negedge clk);
        r_enable      = 1'b1;
        bus.rd_strobe = strobe;
        @(negedge clk);
        r_enable      = 1'b0;
        bus.rd_strobe = 1'b0;
    endtask

    task automatic idle(input int n, input logic lvl);
        rxd = lvl;
        repeat (n) tick(1'b0);
    endtask

    task automatic cpu_read();
        @(negedge clk);
        bus.rd_strobe = 1'b1;
        @(negedge clk);
        bus.rd_strobe = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop, input int strobe_tick,
                              input int stop_at, input bit glitch, input bit chk_commit);
        int   bi;
        int   off;
        logic v;
        for (int t = 1; t <= 160; t++) begin
            if (t > stop_at) break;
            bi  = (t - 1) / 16;
            off = (t - 1) % 16;
            if (bi == 0)      v = 1'b0;
            else if (bi == 9) v = stop;
            else              v = b[bi-1];
            if (glitch && bi >= 1 && bi <= 8 && off == C_GLITCH_OFF) v = ~v;
            rxd = v;
            tick(t == strobe_tick);
            if (chk_commit && t == C_COMMIT - 1)
                check("rda_before_commit", 8'(bus.rda), 8'h00);
            if (chk_commit && t == C_COMMIT) begin
                check("rda_at_commit",  8'(bus.rda), 8'h01);
                check("data_at_commit", bus.data,    b);
            end
        end
    endtask

    initial begin
        bus.rd_strobe = 1'b0;
        vecs[0] = '{1'b0, 8'hA5, 1'b1, 0,  8'hA5, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 8'h3C, 1'b1, 0,  8'h3C, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 8'h55, 1'b0, 40, 8'h3C, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{1'b0, 8'h12, 1'b1, 0,  8'h12, 1'b1, 1'b1, 1'b0};
        vecs[4] = '{1'b1, 8'h11, 1'b1, 0,  8'h11, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{1'b0, 8'h22, 1'b1, 0,  8'h22, 1'b1, 1'b0, 1'b1};

        repeat (3) @(negedge clk);
        check_out("reset", 8'h00, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        idle(4, 1'b1);

        for (int i = 0; i < 6; i++) begin
            if (vecs[i].pre_read) cpu_read();
            send_frame(vecs[i].b, vecs[i].stop, 0, 160, 1'b0, i == 0);
            if (vecs[i].hold_low > 0) idle(vecs[i].hold_low, 1'b0);
            idle(4, 1'b1);
            check_out($sformatf("vec%0d", i), vecs[i].e_data, vecs[i].e_rda,
                      vecs[i].e_fe, vecs[i].e_ov);
        end

        cpu_read();
        check_out("read_clears", 8'h22, 1'b0, 1'b0, 1'b0);

        // Short low glitch on an idle line must be rejected at the start midpoint.
        idle(4, 1'b0);
        idle(20, 1'b1);
        check_out("glitch", 8'h22, 1'b0, 1'b0, 1'b0);
        send_frame(8'h3C, 1'b1, 0, 160, 1'b0, 1'b0);
        idle(4, 1'b1);
        check_out("after_glitch", 8'h3C, 1'b1, 1'b0, 1'b0);

        cpu_read();
        send_frame(8'h66, 1'b1, 0, 160, 1'b0, 1'b0);
        idle(4, 1'b1);
        check_out("first_66", 8'h66, 1'b1, 1'b0, 1'b0);
        send_frame(8'h77, 1'b1, C_COMMIT, 160, 1'b0, 1'b0);
        idle(4, 1'b1);
        check_out("strobe_on_commit", 8'h77, 1'b1, 1'b0, 1'b0);

        // Abort inside data bit 4 with an async reset.
        send_frame(8'hC3, 1'b1, 0, 16 * 5 + 4, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_out("mid_reset", 8'h00, 1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        idle(20, 1'b1);
        check_out("post_reset_idle", 8'h00, 1'b0, 1'b0, 1'b0);
        send_frame(8'hC3, 1'b1, 0, 160, 1'b1, 1'b0);
        idle(4, 1'b1);
        check_out("c3_glitched", 8'hC3, 1'b1, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

`default_nettype wire
